// File: rtl/ysyx_23060184_lsu.sv
// Load/store unit: accepts one instruction from execute, runs at most one
// memory transaction on a valid/ready request channel, formats load data and
// presents the result to writeback. Non-memory instructions pass straight to DONE.
module ysyx_23060184_lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  Evalid,
  output logic                  Mready,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            MemOp,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic                  Mvalid,
  input  logic                  Wready,
  output logic [DATA_WIDTH-1:0] WbData,
  output logic                  MemErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Captured instruction
  logic [DATA_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] store_data_reg;
  logic                  mem_read_reg;
  logic                  mem_write_reg;
  logic [2:0]            mem_op_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] wb_data_reg;

  logic                  accept;
  logic                  in_err;
  logic                  in_is_mem;
  logic [1:0]            off;
  logic [DATA_WIDTH-1:0] store_wdata;
  logic [3:0]            store_wmask;
  logic [DATA_WIDTH-1:0] load_shifted;
  logic [DATA_WIDTH-1:0] load_data;

  assign accept    = (state_reg == IDLE) && Evalid;
  assign in_is_mem = MemRead | MemWrite;
  assign off       = addr_reg[1:0];

  // Classify the incoming instruction: bad funct3, misalignment or read+write
  always_comb begin
    logic bad_op;
    logic misalign;
    bad_op   = (MemOp == 3'b011) || (MemOp[2:1] == 2'b11) ||
               ((MemOp[2:1] == 2'b10) && MemWrite);
    misalign = ((MemOp[1:0] == 2'b01) && ALUResult[0]) ||
               ((MemOp[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
    in_err   = (MemRead & MemWrite) | (in_is_mem & (bad_op | misalign));
  end

  // Store lane placement: replicate data across lanes, enable the addressed bytes
  always_comb begin
    store_wdata = store_data_reg;
    store_wmask = 4'b0000;
    if (mem_write_reg) begin
      case (mem_op_reg[1:0])
        2'b00: begin
          store_wdata = {4{store_data_reg[7:0]}};
          store_wmask = 4'b0001 << off;
        end
        2'b01: begin
          store_wdata = {2{store_data_reg[15:0]}};
          store_wmask = 4'b0011 << off;
        end
        default: begin
          store_wdata = store_data_reg;
          store_wmask = 4'b1111;
        end
      endcase
    end
  end

  // Load formatting: bring the addressed lane down, then sign/zero extend
  always_comb begin
    load_shifted = mem_resp_rdata >> {off, 3'b000};
    case (mem_op_reg)
      3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b100:  load_data = {24'd0, load_shifted[7:0]};
      3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b101:  load_data = {16'd0, load_shifted[15:0]};
      default: load_data = mem_resp_rdata;
    endcase
  end

  // Next-state logic for the single-transaction sequencer
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (Evalid) begin
          if (!in_is_mem || in_err) state_next = DONE;
          else                      state_next = REQ;
        end
      end
      REQ:     if (mem_req_ready)  state_next = WAIT;
      WAIT:    if (mem_resp_valid) state_next = DONE;
      DONE:    if (Wready)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Capture the instruction on acceptance; overwrite the result with load data on response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_reg       <= '0;
      store_data_reg <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_op_reg     <= 3'b000;
      err_reg        <= 1'b0;
      wb_data_reg    <= '0;
    end else if (accept) begin
      addr_reg       <= ALUResult;
      store_data_reg <= WriteData;
      mem_read_reg   <= MemRead;
      mem_write_reg  <= MemWrite;
      mem_op_reg     <= MemOp;
      err_reg        <= in_err;
      wb_data_reg    <= ALUResult;
    end else if ((state_reg == WAIT) && mem_resp_valid && mem_read_reg) begin
      wb_data_reg    <= load_data;
    end
  end

  // Request fields come from captured registers, so they stay stable in REQ
  assign mem_req_valid = (state_reg == REQ);
  assign mem_req_wen   = mem_write_reg;
  assign mem_req_addr  = {addr_reg[DATA_WIDTH-1:2], 2'b00};
  assign mem_req_wdata = store_wdata;
  assign mem_req_wmask = store_wmask;

  assign Mready = (state_reg == IDLE);
  assign Mvalid = (state_reg == DONE);
  assign WbData = wb_data_reg;
  assign MemErr = err_reg;

endmodule
